// File: rtl/elbeth_branch_predictor.sv
// Direct-mapped BTB branch predictor with per-entry saturating direction counters.
// Optional performance counters are enabled by defining ELBETH_BP_STATS_EN.
module elbeth_branch_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CNT_BITS = 2,
  parameter int PC_LSB   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  input  logic            flush_all,
  output logic            mispredict,
  output logic [XLEN-1:0] recover_pc,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - PC_LSB - IDX_W;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - CNT_BITS'(1);

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_BITS'(1);
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_dec(input logic [CNT_BITS-1:0] c);
    return (c == '0) ? c : c - CNT_BITS'(1);
  endfunction

  logic [ENTRIES-1:0]  r_valid;
  logic [TAG_W-1:0]    r_tag    [ENTRIES];
  logic [XLEN-1:0]     r_target [ENTRIES];
  logic [CNT_BITS-1:0] r_cnt    [ENTRIES];

  generate
    if (PC_LSB > 0) begin : g_lsb
      logic w_unused_lsb;
      assign w_unused_lsb = ^if_pc[PC_LSB-1:0];
    end
  endgenerate

  // Fetch-side lookup: purely combinational, sees table state before this edge
  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic             w_if_hit;

  assign w_if_idx    = if_pc[PC_LSB +: IDX_W];
  assign w_if_tag    = if_pc[XLEN-1 -: TAG_W];
  assign w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign pred_taken  = w_if_hit && r_cnt[w_if_idx][CNT_BITS-1];
  assign pred_target = pred_taken ? r_target[w_if_idx] : '0;

  // Resolution-side training decisions
  logic [IDX_W-1:0]    w_upd_idx;
  logic [TAG_W-1:0]    w_upd_tag;
  logic                w_upd_hit;
  logic                w_alloc;
  logic                w_tgt_wr;
  logic                w_cnt_wr;
  logic [CNT_BITS-1:0] w_cnt_nxt;

  assign w_upd_idx = upd_pc[PC_LSB +: IDX_W];
  assign w_upd_tag = upd_pc[XLEN-1 -: TAG_W];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_alloc   = upd_valid && !w_upd_hit && upd_taken;
  assign w_tgt_wr  = upd_valid && ((w_upd_hit && (upd_is_jump || upd_taken)) || w_alloc);
  assign w_cnt_wr  = upd_valid && (w_upd_hit || w_alloc);

  always_comb begin
    w_cnt_nxt = r_cnt[w_upd_idx];
    if (upd_is_jump)    w_cnt_nxt = CNT_MAX;
    else if (!w_upd_hit) w_cnt_nxt = CNT_WT;
    else if (upd_taken) w_cnt_nxt = sat_inc(r_cnt[w_upd_idx]);
    else                w_cnt_nxt = sat_dec(r_cnt[w_upd_idx]);
  end

  always_ff @(posedge clk) begin
    if (w_tgt_wr) begin
      r_tag[w_upd_idx]    <= w_upd_tag;
      r_target[w_upd_idx] <= upd_target;
    end
  end

  // Flush clears validity only; counters keep their training
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= CNT_WNT;
    end else begin
      if (flush_all)    r_valid <= '0;
      else if (w_alloc) r_valid[w_upd_idx] <= 1'b1;
      if (w_cnt_wr) r_cnt[w_upd_idx] <= w_cnt_nxt;
    end
  end

  // Misprediction detection, registered one cycle after resolution
  logic            w_mis;
  logic [XLEN-1:0] w_recover;
  logic            r_mispredict_p1;
  logic [XLEN-1:0] r_recover_pc_p1;

  assign w_mis = upd_valid && ((upd_taken != upd_pred_taken) ||
                 (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
  assign w_recover = upd_taken ? upd_target : upd_pc + XLEN'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mispredict_p1 <= 1'b0;
      r_recover_pc_p1 <= '0;
    end else begin
      r_mispredict_p1 <= w_mis;
      if (w_mis) r_recover_pc_p1 <= w_recover;
    end
  end

  assign mispredict = r_mispredict_p1;
  assign recover_pc = r_recover_pc_p1;

`ifdef ELBETH_BP_STATS_EN
  logic [31:0] r_stat_lookups;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_lookups     <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      r_stat_lookups <= r_stat_lookups + 32'd1;
      if (w_mis) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_lookups     = r_stat_lookups;
  assign stat_mispredicts = r_stat_mispredicts;
`else
  assign stat_lookups     = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_elbeth_branch_predictor.sv
// Directed, table-driven bench for elbeth_branch_predictor (default parameters).
module tb_elbeth_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_is_jump = 1'b0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_target = '0;
  logic        flush_all = 1'b0;
  logic        mispredict;
  logic [31:0] recover_pc;
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispredicts;

  always #5 clk = ~clk;

  elbeth_branch_predictor dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .flush_all(flush_all), .mispredict(mispredict), .recover_pc(recover_pc),
    .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
  );

  typedef struct {
    logic [31:0] if_pc;
    logic        uv;
    logic [31:0] upc;
    logic        jmp;
    logic        tk;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic        fl;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_mis;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic [31:0] ipc, input logic uv, input logic [31:0] upc,
                     input logic jmp, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt, input logic fl,
                     input logic e_pt, input logic [31:0] e_ptgt,
                     input logic e_mis, input logic [31:0] e_rpc);
    vec_t v;
    v.if_pc = ipc; v.uv = uv; v.upc = upc; v.jmp = jmp; v.tk = tk; v.tgt = tgt;
    v.ptk = ptk; v.ptgt = ptgt; v.fl = fl; v.e_pt = e_pt; v.e_ptgt = e_ptgt;
    v.e_mis = e_mis; v.e_rpc = e_rpc;
    vecs.push_back(v);
  endtask

  initial begin
    //   if_pc   uv upc      j tk tgt      ptk ptgt    fl  pt ptgt     mis rpc
    add(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h0);   // 0
    add(32'h100, 1, 32'h100, 0, 1, 32'h180, 0, 32'h0,   0, 0, 32'h0,   1, 32'h180); // 1 alloc
    add(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h180, 0, 32'h180); // 2
    add(32'h100, 1, 32'h100, 0, 0, 32'h0,   1, 32'h180, 0, 1, 32'h180, 1, 32'h104); // 3 cnt 2->1
    add(32'h100, 1, 32'h100, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h104); // 4 1->0
    add(32'h100, 1, 32'h100, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h104); // 5 sat 0
    add(32'h100, 1, 32'h100, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h104); // 6 sat 0
    add(32'h100, 1, 32'h100, 0, 1, 32'h180, 0, 32'h0,   0, 0, 32'h0,   1, 32'h180); // 7 0->1
    add(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h180); // 8
    add(32'h100, 1, 32'h100, 0, 1, 32'h180, 0, 32'h0,   0, 0, 32'h0,   1, 32'h180); // 9 1->2
    add(32'h100, 1, 32'h100, 0, 1, 32'h180, 1, 32'h180, 0, 1, 32'h180, 0, 32'h180); // 10 2->3
    add(32'h100, 1, 32'h100, 0, 1, 32'h180, 1, 32'h180, 0, 1, 32'h180, 0, 32'h180); // 11 sat 3
    add(32'h100, 1, 32'h100, 0, 0, 32'h0,   1, 32'h180, 0, 1, 32'h180, 1, 32'h104); // 12 3->2
    add(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h180, 0, 32'h104); // 13
    add(32'h140, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h104); // 14 alias miss
    add(32'h140, 1, 32'h140, 0, 1, 32'h200, 0, 32'h0,   0, 0, 32'h0,   1, 32'h200); // 15 evict
    add(32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h200); // 16
    add(32'h140, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h200, 0, 32'h200); // 17
    add(32'h140, 1, 32'h200, 0, 0, 32'h0,   1, 32'h280, 0, 1, 32'h200, 1, 32'h204); // 18 miss NT
    add(32'h140, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h200, 0, 32'h204); // 19
    add(32'h244, 1, 32'h244, 1, 1, 32'h300, 1, 32'h280, 0, 0, 32'h0,   1, 32'h300); // 20 wrong tgt
    add(32'h244, 1, 32'h244, 0, 0, 32'h0,   1, 32'h300, 0, 1, 32'h300, 1, 32'h248); // 21 3->2
    add(32'h244, 1, 32'h244, 0, 0, 32'h0,   1, 32'h300, 0, 1, 32'h300, 1, 32'h248); // 22 2->1
    add(32'h244, 1, 32'h244, 1, 1, 32'h310, 0, 32'h0,   0, 0, 32'h0,   1, 32'h310); // 23 jump->max
    add(32'h244, 1, 32'h244, 0, 0, 32'h0,   1, 32'h310, 0, 1, 32'h310, 1, 32'h248); // 24 3->2
    add(32'h244, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h310, 0, 32'h248); // 25
    add(32'h140, 1, 32'h104, 0, 1, 32'h400, 0, 32'h0,   1, 1, 32'h200, 1, 32'h400); // 26 flush+upd
    add(32'h140, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h400); // 27
    add(32'h244, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h400); // 28
    add(32'h104, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h400); // 29
    add(32'h244, 1, 32'h244, 0, 1, 32'h320, 0, 32'h0,   0, 0, 32'h0,   1, 32'h320); // 30 realloc
    add(32'h244, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h320, 0, 32'h320); // 31

    repeat (2) @(negedge clk);
    if_pc = 32'h100;
    #1;
    check("reset_mispredict", {31'b0, mispredict}, 32'd0);
    check("reset_recover_pc", recover_pc, 32'h0);
    check("reset_pred_taken", {31'b0, pred_taken}, 32'd0);
    check("reset_pred_target", pred_target, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if_pc = vecs[i].if_pc;       upd_valid = vecs[i].uv;
      upd_pc = vecs[i].upc;        upd_is_jump = vecs[i].jmp;
      upd_taken = vecs[i].tk;      upd_target = vecs[i].tgt;
      upd_pred_taken = vecs[i].ptk; upd_pred_target = vecs[i].ptgt;
      flush_all = vecs[i].fl;
      #1;
      check($sformatf("v%0d_pred_taken", i), {31'b0, pred_taken}, {31'b0, vecs[i].e_pt});
      check($sformatf("v%0d_pred_target", i), pred_target, vecs[i].e_ptgt);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_mispredict", i), {31'b0, mispredict}, {31'b0, vecs[i].e_mis});
      check($sformatf("v%0d_recover_pc", i), recover_pc, vecs[i].e_rpc);
    end

    // Reset arriving while a mispredict pulse is showing drops it at once
    @(negedge clk);
    if_pc = 32'h244; upd_valid = 1'b1; upd_pc = 32'h244; upd_is_jump = 1'b0;
    upd_taken = 1'b1; upd_target = 32'h500; upd_pred_taken = 1'b0;
    upd_pred_target = 32'h0; flush_all = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_mispredict", {31'b0, mispredict}, 32'd1);
    check("pre_rst_recover_pc", recover_pc, 32'h500);
    #1 rst = 1'b1;
    #1;
    check("async_rst_mispredict", {31'b0, mispredict}, 32'd0);
    check("async_rst_recover_pc", recover_pc, 32'h0);
    check("async_rst_pred_taken", {31'b0, pred_taken}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_held_mispredict", {31'b0, mispredict}, 32'd0);
    @(negedge clk);
    upd_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_pred_taken", {31'b0, pred_taken}, 32'd0);

    // Statistics counters from a clean reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
`ifdef ELBETH_BP_STATS_EN
    check("stat_lookups_10", stat_lookups, 32'd10);
`else
    check("stat_lookups_off", stat_lookups, 32'd0);
`endif
    check("stat_mispredicts_zero", stat_mispredicts, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
